aes_round_ctrl: RTL and testbench

- Iterative AES-128 encryption sequencer. Owns the 128-bit state and round-key registers, and runs one round per clock through the external combinational round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) and the external key-expansion step.
- Generates Rcon, the round counter and the final-round MixColumns bypass.
- Presents a valid/ready handshake on both the plaintext side and the ciphertext side.

---
 rtl/aes_round_ctrl_if.sv | 19 +
 rtl/aes_round_ctrl.sv | 111 +++++++++++
 tb/tb_aes_round_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Plaintext-side and ciphertext-side valid/ready handshake bundle for
// aes_round_ctrl.
//   in_valid/in_ready/in_pt/in_key    : block + key offered to the controller
//   out_valid/out_ready/out_ct        : ciphertext returned to the consumer
// slave  : the controller's view; master : the producer/consumer's view.
interface aes_round_ctrl_if #(parameter int DW = 128);
  logic          in_valid;
  logic          in_ready;
  logic [0:DW-1] in_pt;
  logic [0:DW-1] in_key;
  logic          out_valid;
  logic          out_ready;
  logic [0:DW-1] out_ct;

  modport slave  (input  in_valid, in_pt, in_key, out_ready,
                  output in_ready, out_valid, out_ct);
  modport master (output in_valid, in_pt, in_key, out_ready,
                  input  in_ready, out_valid, out_ct);
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer. Holds the cipher state and the
// running round key, and steps one round per clock through an external
// combinational round datapath and an external key-expansion step.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   bus (slave)           : in_* plaintext/key handshake, out_* ciphertext
//   busy, round_o         : block in flight, current round (0 when idle)
//   dp_state/dp_key/dp_final -> round datapath, dp_result <- its output
//   ks_key/ks_rcon        -> key expansion,    ks_next   <- its output
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.slave  bus,
  output logic             busy,
  output logic [3:0]       round_o,
  output logic [0:DW-1]    dp_state,
  output logic [0:DW-1]    dp_key,
  output logic             dp_final,
  input  logic [0:DW-1]    dp_result,
  output logic [0:DW-1]    ks_key,
  output logic [7:0]       ks_rcon,
  input  logic [0:DW-1]    ks_next
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} st_t;

  localparam logic [3:0] LAST_FULL = 4'(NR - 1);

  st_t           st, st_nxt;
  logic [0:DW-1] state_reg, key_reg;
  logic [3:0]    round;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.in_valid)   st_nxt = ROUND;
      ROUND:   if (round == LAST_FULL) st_nxt = FINAL;
      FINAL:   st_nxt = DONE;
      DONE:    if (bus.out_ready)  st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Initial AddRoundKey is folded into the accept edge, so the datapath
  // only ever sees rounds 1..NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      key_reg   <= '0;
      round     <= '0;
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          state_reg <= bus.in_pt ^ bus.in_key;
          key_reg   <= bus.in_key;
          round     <= 4'd1;
        end
        ROUND: begin
          state_reg <= dp_result;
          key_reg   <= ks_next;
          round     <= round + 4'd1;
        end
        FINAL: begin
          state_reg <= dp_result;
          key_reg   <= ks_next;
          round     <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  wire running = (st == ROUND) || (st == FINAL);

  assign bus.in_ready  = (st == IDLE);
  assign bus.out_valid = (st == DONE);
  // state_reg only moves while running, so it is already stable in DONE.
  assign bus.out_ct    = state_reg;
  assign busy          = (st != IDLE);
  assign round_o       = round;
  assign dp_state      = state_reg;
  assign dp_key        = ks_next;
  assign dp_final      = (st == FINAL);
  assign ks_key        = key_reg;
  assign ks_rcon       = running ? rcon(round) : 8'h00;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy, dp_final;
  logic [3:0]    round_o;
  logic [7:0]    ks_rcon;
  logic [0:127]  dp_state, dp_key, dp_result, ks_key, ks_next;

  int tests = 0;
  int fails = 0;

  aes_round_ctrl_if #(.DW(128)) bus ();

  aes_round_ctrl #(.NR(10), .DW(128)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .busy(busy), .round_o(round_o),
    .dp_state(dp_state), .dp_key(dp_key), .dp_final(dp_final), .dp_result(dp_result),
    .ks_key(ks_key), .ks_rcon(ks_rcon), .ks_next(ks_next)
  );

  always #5 clk = ~clk;

  // ---- golden AES round / key-expansion models ----
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01, s = x, b;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] st, input logic [0:127] rk,
                                             input logic fin);
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) t[i] = sbox(st[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) u[r + 4*c] = t[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
      if (!fin) begin
        u[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        u[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        u[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        u[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = u[i] ^ rk[8*i +: 8];
    return o;
  endfunction

  function automatic logic [0:127] key_exp(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] tmp, w0, w1, w2, w3;
    tmp = {sbox(k[104 +: 8]) ^ rc, sbox(k[112 +: 8]), sbox(k[120 +: 8]), sbox(k[96 +: 8])};
    w0 = k[0 +: 32] ^ tmp;
    w1 = k[32 +: 32] ^ w0;
    w2 = k[64 +: 32] ^ w1;
    w3 = k[96 +: 32] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign ks_next   = key_exp(ks_key, ks_rcon);
  assign dp_result = aes_round(dp_state, dp_key, dp_final);

  // ---- helpers ----
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one block for a single cycle; returns just after the accept edge.
  task automatic start(input logic [0:127] pt, input logic [0:127] key);
    bus.in_valid = 1'b1; bus.in_pt = pt; bus.in_key = key;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_pt = '0; bus.in_key = '0; bus.out_ready = 1'b0;

    // reset state
    #12;
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_ct",    bus.out_ct, 128'd0);
    check("rst_busy",      128'(busy), 128'd0);
    check("rst_round",     128'(round_o), 128'd0);
    check("rst_rcon",      128'(ks_rcon), 128'd0);
    check("rst_final",     128'(dp_final), 128'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  128'(bus.in_ready), 128'd1);

    // FIPS-197 App. B, latency 10 clocks after accept
    tick();
    start(PT_B, KEY_B);
    check("b_busy", 128'(busy), 128'd1);
    check("b_round1", 128'(round_o), 128'd1);
    wait_done(n);
    check("b_latency", 128'(n), 128'd10);
    check("b_ct", bus.out_ct, CT_B);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("b_idle_ready", 128'(bus.in_ready), 128'd1);
    check("b_idle_valid", 128'(bus.out_valid), 128'd0);

    // FIPS-197 C.1, Rcon sequence and final-round flag
    start(PT_C, KEY_C);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("c_rcon%0d", i + 1), 128'(ks_rcon), 128'(rcon_exp[i]));
      check($sformatf("c_final%0d", i + 1), 128'(dp_final), 128'(i == 9));
      check($sformatf("c_round%0d", i + 1), 128'(round_o), 128'(i + 1));
      tick();
    end
    check("c_valid", 128'(bus.out_valid), 128'd1);
    check("c_ct", bus.out_ct, CT_C);

    // backpressure: hold out_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 128'(bus.out_valid), 128'd1);
      check("bp_ct", bus.out_ct, CT_C);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_rcon", 128'(ks_rcon), 128'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_ready", 128'(bus.in_ready), 128'd1);
    check("bp_release_busy", 128'(busy), 128'd0);
    check("bp_release_valid", 128'(bus.out_valid), 128'd0);

    // busy rejection: second block offered during round 4
    start(PT_B, KEY_B);
    tick(); tick(); tick();
    check("rej_round4", 128'(round_o), 128'd4);
    bus.in_valid = 1'b1; bus.in_pt = PT_C; bus.in_key = KEY_C;
    check("rej_in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    bus.in_valid = 1'b0;
    check("rej_round5", 128'(round_o), 128'd5);
    wait_done(n);
    check("rej_remaining", 128'(n), 128'd6);
    check("rej_ct", bus.out_ct, CT_B);
    // second vector waits for DONE->IDLE before it is taken
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("rej_idle_ready", 128'(bus.in_ready), 128'd1);
    check("rej_idle_round", 128'(round_o), 128'd0);
    tick();
    bus.in_valid = 1'b0;
    check("rej_accept_round", 128'(round_o), 128'd1);
    wait_done(n);
    check("rej2_latency", 128'(n), 128'd10);
    check("rej2_ct", bus.out_ct, CT_C);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // async reset mid-block (round 5), then a clean rerun
    start(PT_B, KEY_B);
    tick(); tick(); tick(); tick();
    check("ar_round5", 128'(round_o), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 128'(bus.out_valid), 128'd0);
    check("ar_round", 128'(round_o), 128'd0);
    check("ar_busy", 128'(busy), 128'd0);
    check("ar_in_ready", 128'(bus.in_ready), 128'd1);
    check("ar_ct", bus.out_ct, 128'd0);
    #1 rst_n = 1'b1;
    tick();
    check("ar_still_idle", 128'(busy), 128'd0);
    start(PT_B, KEY_B);
    wait_done(n);
    check("ar_rerun_latency", 128'(n), 128'd10);
    check("ar_rerun_ct", bus.out_ct, CT_B);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ar_rerun_idle", 128'(bus.in_ready), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
